// File: rtl/morse_timed_decoder.sv
// Timed Morse decoder: measures key mark/space runs, classifies dots and dashes,
// and emits the ASCII code of each completed letter (plus optional word space).
module morse_timed_decoder #(
    parameter int unsigned UNIT_CYCLES   = 4,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned WORD_SPACE_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_in,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       err
);

    localparam logic [CNT_W-1:0] DASH_MIN   = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(3 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(7 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {IDLE, MARK, SPACE, WORD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       code_q, code_d;
    logic [2:0]       len_q, len_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       char_q, char_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             is_dot;
    logic [8:0]       lut;

    // Returns {hit, ascii}; code holds symbols LSB-first, 1 = dot, 0 = dash.
    function automatic logic [8:0] lookup(input logic [2:0] len, input logic [4:0] code);
        logic [8:0] r;
        r = {1'b0, 8'h3F};
        case ({len, code})
            {3'd2, 5'b00001}: r = {1'b1, 8'h41}; // A
            {3'd4, 5'b01110}: r = {1'b1, 8'h42}; // B
            {3'd4, 5'b01010}: r = {1'b1, 8'h43}; // C
            {3'd3, 5'b00110}: r = {1'b1, 8'h44}; // D
            {3'd1, 5'b00001}: r = {1'b1, 8'h45}; // E
            {3'd4, 5'b01011}: r = {1'b1, 8'h46}; // F
            {3'd3, 5'b00100}: r = {1'b1, 8'h47}; // G
            {3'd4, 5'b01111}: r = {1'b1, 8'h48}; // H
            {3'd2, 5'b00011}: r = {1'b1, 8'h49}; // I
            {3'd4, 5'b00001}: r = {1'b1, 8'h4A}; // J
            {3'd3, 5'b00010}: r = {1'b1, 8'h4B}; // K
            {3'd4, 5'b01101}: r = {1'b1, 8'h4C}; // L
            {3'd2, 5'b00000}: r = {1'b1, 8'h4D}; // M
            {3'd2, 5'b00010}: r = {1'b1, 8'h4E}; // N
            {3'd3, 5'b00000}: r = {1'b1, 8'h4F}; // O
            {3'd4, 5'b01001}: r = {1'b1, 8'h50}; // P
            {3'd4, 5'b00100}: r = {1'b1, 8'h51}; // Q
            {3'd3, 5'b00101}: r = {1'b1, 8'h52}; // R
            {3'd3, 5'b00111}: r = {1'b1, 8'h53}; // S
            {3'd1, 5'b00000}: r = {1'b1, 8'h54}; // T
            {3'd3, 5'b00011}: r = {1'b1, 8'h55}; // U
            {3'd4, 5'b00111}: r = {1'b1, 8'h56}; // V
            {3'd3, 5'b00001}: r = {1'b1, 8'h57}; // W
            {3'd4, 5'b00110}: r = {1'b1, 8'h58}; // X
            {3'd4, 5'b00010}: r = {1'b1, 8'h59}; // Y
            {3'd4, 5'b01100}: r = {1'b1, 8'h5A}; // Z
            {3'd5, 5'b00000}: r = {1'b1, 8'h30};
            {3'd5, 5'b00001}: r = {1'b1, 8'h31};
            {3'd5, 5'b00011}: r = {1'b1, 8'h32};
            {3'd5, 5'b00111}: r = {1'b1, 8'h33};
            {3'd5, 5'b01111}: r = {1'b1, 8'h34};
            {3'd5, 5'b11111}: r = {1'b1, 8'h35};
            {3'd5, 5'b11110}: r = {1'b1, 8'h36};
            {3'd5, 5'b11100}: r = {1'b1, 8'h37};
            {3'd5, 5'b11000}: r = {1'b1, 8'h38};
            {3'd5, 5'b10000}: r = {1'b1, 8'h39};
            default:          r = {1'b0, 8'h3F};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        char_d  = char_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        is_dot  = (cnt_q < DASH_MIN);
        lut     = lookup(len_q, code_q);

        case (state_q)
            IDLE: begin
                if (key_in) begin
                    state_d = MARK;
                    cnt_d   = CNT_W'(1);
                end
            end
            MARK: begin
                if (key_in) begin
                    cnt_d = cnt_inc;
                end else begin
                    if (len_q < 3'd5) begin
                        code_d = code_q | (5'(is_dot) << len_q);
                        len_d  = len_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    state_d = SPACE;
                    cnt_d   = CNT_W'(1);
                end
            end
            SPACE: begin
                if (key_in) begin
                    state_d = MARK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                    // Letter gap reached: emit and start watching for a word gap.
                    if (cnt_inc == LETTER_GAP) begin
                        valid_d = 1'b1;
                        if (ovf_q || !lut[8]) begin
                            char_d = 8'h3F;
                            err_d  = 1'b1;
                        end else begin
                            char_d = lut[7:0];
                        end
                        code_d  = '0;
                        len_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = WORD;
                    end
                end
            end
            WORD: begin
                if (key_in) begin
                    state_d = MARK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == WORD_GAP) begin
                        if (WORD_SPACE_EN == 1) begin
                            valid_d = 1'b1;
                            char_d  = 8'h20;
                        end
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign char_out   = char_q;
    assign char_valid = valid_q;
    assign err        = err_q;

endmodule
